// File: rtl/exception_sequencer.sv
// ============================================================================
// Module      : exception_sequencer
// Description : Sequences exception/interrupt entry, ERET and MTC0 traffic onto
//               the CP0 single write port; flushes, stalls and redirects the
//               pipeline. Optional macro EXC_BD_EN enables branch-delay EPC fixup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exception_sequencer #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int          IRQ_LINES  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exc_req,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_pc,
    input  logic                 exc_bd,
    input  logic                 eret_req,
    input  logic [IRQ_LINES-1:0] irq,
    input  logic                 mtc0_req,
    input  logic [4:0]           mtc0_addr,
    input  logic [5:0]           mtc0_sel,
    input  logic [31:0]          mtc0_din,
    input  logic [31:0]          cp0_epc,
    output logic [4:0]           cp0_addr,
    output logic [5:0]           cp0_sel,
    output logic [31:0]          cp0_din,
    output logic                 cp0_write,
    output logic                 stall,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc
);

    localparam logic [4:0]  C_REG_STATUS = 5'd12;
    localparam logic [4:0]  C_REG_CAUSE  = 5'd13;
    localparam logic [4:0]  C_REG_EPC    = 5'd14;
    localparam logic [31:0] C_EXL_MASK   = 32'h0000_0002;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_EPC     = 3'd1,
        S_WR_CAUSE   = 3'd2,
        S_WR_STATUS  = 3'd3,
        S_REDIR      = 3'd4,
        S_ERET_WR    = 3'd5,
        S_ERET_REDIR = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [31:0]            r_status;
    logic [4:0]             r_code;
    logic [31:0]            r_epc;
    logic [IRQ_LINES-1:0]   r_ip;
    logic                   r_bd;

    logic                   w_irq_take;
    logic                   w_take_exc;
    logic [31:0]            w_epc;
    logic                   w_bd;
    logic [31:0]            w_cause;

    assign w_irq_take = (|(irq & r_status[10 +: IRQ_LINES])) & r_status[0] & ~r_status[1];
    assign w_take_exc = exc_req | w_irq_take;

`ifdef EXC_BD_EN
    // A faulting delay-slot instruction restarts at its branch.
    assign w_epc = exc_bd ? (exc_pc - 32'd4) : exc_pc;
    assign w_bd  = exc_bd;
`else
    logic w_unused_bd;
    assign w_unused_bd = exc_bd;
    assign w_epc       = exc_pc;
    assign w_bd        = 1'b0;
`endif

    always_comb begin
        w_cause                  = '0;
        w_cause[31]              = r_bd;
        w_cause[10 +: IRQ_LINES] = r_ip;
        w_cause[6:2]             = r_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Entry context is captured only in the accepting cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= '0;
            r_epc  <= '0;
            r_ip   <= '0;
            r_bd   <= 1'b0;
        end else if (r_state == S_IDLE && w_take_exc) begin
            r_code <= exc_req ? exc_code : 5'd0;
            r_epc  <= w_epc;
            r_ip   <= irq;
            r_bd   <= w_bd;
        end
    end

    // The shadow follows every write that reaches Status, internal or MTC0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
        end else if (cp0_write && cp0_addr == C_REG_STATUS && cp0_sel[2:0] == 3'd0) begin
            r_status <= cp0_din;
        end
    end

    always_comb begin
        w_next         = r_state;
        cp0_addr       = '0;
        cp0_sel        = '0;
        cp0_din        = '0;
        cp0_write      = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        case (r_state)
            S_IDLE: begin
                if (w_take_exc) begin
                    flush  = 1'b1;
                    stall  = 1'b1;
                    w_next = S_WR_EPC;
                end else if (eret_req) begin
                    flush  = 1'b1;
                    stall  = 1'b1;
                    w_next = S_ERET_WR;
                end else if (mtc0_req) begin
                    cp0_write = 1'b1;
                    cp0_addr  = mtc0_addr;
                    cp0_sel   = mtc0_sel;
                    cp0_din   = mtc0_din;
                end
            end
            S_WR_EPC: begin
                stall     = 1'b1;
                cp0_write = 1'b1;
                cp0_addr  = C_REG_EPC;
                cp0_din   = r_epc;
                w_next    = S_WR_CAUSE;
            end
            S_WR_CAUSE: begin
                stall     = 1'b1;
                cp0_write = 1'b1;
                cp0_addr  = C_REG_CAUSE;
                cp0_din   = w_cause;
                w_next    = S_WR_STATUS;
            end
            S_WR_STATUS: begin
                stall     = 1'b1;
                cp0_write = 1'b1;
                cp0_addr  = C_REG_STATUS;
                cp0_din   = r_status | C_EXL_MASK;
                w_next    = S_REDIR;
            end
            S_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = EXC_VECTOR;
                w_next         = S_IDLE;
            end
            S_ERET_WR: begin
                stall     = 1'b1;
                cp0_write = 1'b1;
                cp0_addr  = C_REG_STATUS;
                cp0_din   = r_status & ~C_EXL_MASK;
                w_next    = S_ERET_REDIR;
            end
            S_ERET_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = cp0_epc;
                w_next         = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Reset silences every output immediately, including mid-sequence.
        if (rst) begin
            w_next         = S_IDLE;
            cp0_addr       = '0;
            cp0_sel        = '0;
            cp0_din        = '0;
            cp0_write      = 1'b0;
            stall          = 1'b0;
            flush          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exception_sequencer.sv
// ============================================================================
// Module      : tb_exception_sequencer
// Description : Scoreboard bench for exception_sequencer (CP0 writes/redirects).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exception_sequencer;

    localparam logic [31:0] C_VEC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret_req;
    logic [5:0]  irq;
    logic        mtc0_req;
    logic [4:0]  mtc0_addr;
    logic [5:0]  mtc0_sel;
    logic [31:0] mtc0_din;
    logic [31:0] cp0_epc;
    logic [4:0]  cp0_addr;
    logic [5:0]  cp0_sel;
    logic [31:0] cp0_din;
    logic        cp0_write;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    exception_sequencer #(.EXC_VECTOR(C_VEC), .IRQ_LINES(6)) dut (
        .clk(clk), .rst(rst),
        .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .eret_req(eret_req), .irq(irq),
        .mtc0_req(mtc0_req), .mtc0_addr(mtc0_addr), .mtc0_sel(mtc0_sel), .mtc0_din(mtc0_din),
        .cp0_epc(cp0_epc),
        .cp0_addr(cp0_addr), .cp0_sel(cp0_sel), .cp0_din(cp0_din), .cp0_write(cp0_write),
        .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [5:0]  sel;
        logic [31:0] din;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_redir[$];
    wr_t         mon_e;
    logic [31:0] mon_pc;
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] m_status;

    // Scoreboard: every CP0 write and redirect outside reset must match the queue head.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (cp0_write === 1'b1) begin
                compared++;
                if (exp_wr.size() == 0) begin
                    mismatched++;
                    $display("FAIL cp0_write_unexpected: got addr %0d din %h, required no write", cp0_addr, cp0_din);
                end else begin
                    mon_e = exp_wr.pop_front();
                    if (cp0_addr !== mon_e.addr || cp0_sel !== mon_e.sel || cp0_din !== mon_e.din) begin
                        mismatched++;
                        $display("FAIL cp0_write: got addr %0d sel %0d din %h, required addr %0d sel %0d din %h",
                                 cp0_addr, cp0_sel, cp0_din, mon_e.addr, mon_e.sel, mon_e.din);
                    end
                end
            end
            if (redirect_valid === 1'b1) begin
                compared++;
                if (exp_redir.size() == 0) begin
                    mismatched++;
                    $display("FAIL redirect_unexpected: got pc %h, required no redirect", redirect_pc);
                end else begin
                    mon_pc = exp_redir.pop_front();
                    if (redirect_pc !== mon_pc) begin
                        mismatched++;
                        $display("FAIL redirect_pc: got %h, required %h", redirect_pc, mon_pc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_req   = 1'b0;
        exc_code  = '0;
        exc_pc    = '0;
        exc_bd    = 1'b0;
        eret_req  = 1'b0;
        mtc0_req  = 1'b0;
        mtc0_addr = '0;
        mtc0_sel  = '0;
        mtc0_din  = '0;
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [5:0] s, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.sel  = s;
        e.din  = d;
        exp_wr.push_back(e);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        exc_req   = 1'b1;
        eret_req  = 1'b1;
        mtc0_req  = 1'b1;
        mtc0_addr = 5'd12;
        mtc0_din  = 32'hFFFF_FFFF;
        tick();
        @(negedge clk);
        compared++;
        if ({flush, stall, cp0_write, redirect_valid} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got flush/stall/wr/redir %b, required 0000",
                     {flush, stall, cp0_write, redirect_valid});
        end
        compared++;
        if (cp0_din !== 32'd0 || cp0_addr !== 5'd0 || redirect_pc !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_data: got din %h addr %0d rpc %h, required all zero", cp0_din, cp0_addr, redirect_pc);
        end
        tick();
        clear_inputs();
        rst      = 1'b0;
        m_status = 32'd0;
        tick();
    endtask

    // Drives one exception (optionally with competing ERET/MTC0) and checks the control timeline.
    task automatic run_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd, input logic others);
        logic [31:0] epc;
        logic [31:0] cause;
        epc   = pc;
        cause = {25'd0, code, 2'b00};
`ifdef EXC_BD_EN
        if (bd) begin
            epc       = pc - 32'd4;
            cause[31] = 1'b1;
        end
`endif
        push_wr(5'd14, 6'd0, epc);
        push_wr(5'd13, 6'd0, cause);
        push_wr(5'd12, 6'd0, m_status | 32'h2);
        exp_redir.push_back(C_VEC);
        m_status = m_status | 32'h2;

        exc_req  = 1'b1;
        exc_code = code;
        exc_pc   = pc;
        exc_bd   = bd;
        if (others) begin
            eret_req  = 1'b1;
            mtc0_req  = 1'b1;
            mtc0_addr = 5'd12;
            mtc0_din  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        compared++;
        if ({flush, stall, cp0_write} !== 3'b110) begin
            mismatched++;
            $display("FAIL exc_accept: got flush/stall/wr %b, required 110", {flush, stall, cp0_write});
        end
        tick();
        clear_inputs();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            compared++;
            if ({flush, stall, cp0_write} !== 3'b011) begin
                mismatched++;
                $display("FAIL exc_seq_n%0d: got flush/stall/wr %b, required 011", i, {flush, stall, cp0_write});
            end
            tick();
        end
        @(negedge clk);
        compared++;
        if ({flush, stall, redirect_valid} !== 3'b001) begin
            mismatched++;
            $display("FAIL exc_redir_cycle: got flush/stall/redir %b, required 001", {flush, stall, redirect_valid});
        end
        tick();
        @(negedge clk);
        compared++;
        if ({redirect_valid, cp0_write, stall} !== 3'b000) begin
            mismatched++;
            $display("FAIL exc_done_idle: got redir/wr/stall %b, required 000", {redirect_valid, cp0_write, stall});
        end
        tick();
    endtask

    task automatic test_exception();
        run_exc(5'd4, 32'h0040_0010, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid();
        push_wr(5'd14, 6'd0, 32'h0040_0040);
        exc_req  = 1'b1;
        exc_code = 5'd1;
        exc_pc   = 32'h0040_0040;
        tick();
        clear_inputs();
        @(negedge clk);
        compared++;
        if (cp0_write !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid_epc: got cp0_write %b, required 1", cp0_write);
        end
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        m_status = 32'd0;
        @(negedge clk);
        compared++;
        if ({cp0_write, stall, flush, redirect_valid} !== 4'b0000) begin
            mismatched++;
            $display("FAIL rst_mid_after: got wr/stall/flush/redir %b, required 0000",
                     {cp0_write, stall, flush, redirect_valid});
        end
        repeat (4) tick();
    endtask

    task automatic test_mtc0(input logic [5:0] sel, input logic [31:0] din);
        push_wr(5'd12, sel, din);
        if (sel[2:0] == 3'd0) m_status = din;
        mtc0_req  = 1'b1;
        mtc0_addr = 5'd12;
        mtc0_sel  = sel;
        mtc0_din  = din;
        @(negedge clk);
        compared++;
        if ({cp0_write, stall, flush} !== 3'b100) begin
            mismatched++;
            $display("FAIL mtc0_pass: got wr/stall/flush %b, required 100", {cp0_write, stall, flush});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_interrupt();
        push_wr(5'd14, 6'd0, 32'h0040_0020);
        push_wr(5'd13, 6'd0, 32'h0000_0400);
        push_wr(5'd12, 6'd0, m_status | 32'h2);
        exp_redir.push_back(C_VEC);
        m_status = m_status | 32'h2;
        exc_pc = 32'h0040_0020;
        irq    = 6'b000001;
        @(negedge clk);
        compared++;
        if ({flush, stall} !== 2'b11) begin
            mismatched++;
            $display("FAIL irq_accept: got flush/stall %b, required 11", {flush, stall});
        end
        tick();
        exc_pc = 32'h0;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if ({flush, stall} !== 2'b00) begin
                mismatched++;
                $display("FAIL irq_no_reentry_%0d: got flush/stall %b, required 00", i, {flush, stall});
            end
            tick();
        end
        irq = 6'b0;
        tick();
    endtask

    task automatic test_eret();
        push_wr(5'd12, 6'd0, m_status & ~32'h2);
        exp_redir.push_back(32'h0040_0020);
        m_status = m_status & ~32'h2;
        cp0_epc  = 32'h0040_0020;
        eret_req = 1'b1;
        @(negedge clk);
        compared++;
        if ({flush, stall, cp0_write} !== 3'b110) begin
            mismatched++;
            $display("FAIL eret_accept: got flush/stall/wr %b, required 110", {flush, stall, cp0_write});
        end
        tick();
        eret_req = 1'b0;
        @(negedge clk);
        compared++;
        if (cp0_write !== 1'b1 || redirect_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL eret_wr_cycle: got wr %b redir %b, required 1 0", cp0_write, redirect_valid);
        end
        tick();
        @(negedge clk);
        compared++;
        if (redirect_valid !== 1'b1 || cp0_write !== 1'b0) begin
            mismatched++;
            $display("FAIL eret_redir_cycle: got redir %b wr %b, required 1 0", redirect_valid, cp0_write);
        end
        tick();
        cp0_epc = 32'h0;
        tick();
    endtask

    task automatic test_priority();
        run_exc(5'd10, 32'h0040_0030, 1'b0, 1'b1);
    endtask

    task automatic test_bd();
        run_exc(5'd5, 32'h0040_0014, 1'b1, 1'b0);
    endtask

    initial begin
        clear_inputs();
        rst      = 1'b1;
        irq      = '0;
        cp0_epc  = '0;
        m_status = '0;
        test_reset();
        test_exception();
        test_rst_mid();
        test_mtc0(6'd0, 32'h0000_0401);
        test_mtc0(6'd1, 32'hFFFF_FFFF);
        test_interrupt();
        test_eret();
        test_priority();
        test_mtc0(6'd0, 32'h0000_0401);
        test_bd();
        compared++;
        if (exp_wr.size() != 0 || exp_redir.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d writes %0d redirects outstanding, required 0 0",
                     exp_wr.size(), exp_redir.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
